// File: rtl/dsp_fir_tdm.sv
// rtl/dsp_fir_tdm.sv - time-multiplexed binary32 FIR, one fp multiply-accumulate datapath per filter
// Optional FIR_STATUS_EN: invalid/overflow/underflow flags ORed over the accumulate steps of each sample.
module dsp_fir_tdm #(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAC_LAT    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ce_i,
    input  logic                          coef_we_i,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr_i,
    input  logic [DATA_WIDTH-1:0]         coef_data_i,
    input  logic                          x_valid_i,
    output logic                          x_ready_o,
    input  logic [DATA_WIDTH-1:0]         x_i,
    output logic                          y_valid_o,
    output logic [DATA_WIDTH-1:0]         y_o,
    output logic                          busy_o,
    output logic                          invalid_o,
    output logic                          overflow_o,
    output logic                          underflow_o
);
    localparam int TAP_AW  = $clog2(NUM_TAPS);
    localparam int CNT_MAX = (NUM_TAPS > MAC_LAT) ? NUM_TAPS : MAC_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int P_LEN   = MAC_LAT - 2;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Denormal operands and results are flushed to signed zero; round to nearest even.
    // Return value is {invalid, overflow, underflow, result}.
    function automatic logic [34:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s, g, st;
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [47:0]        prod;
        logic [24:0]        mant;
        logic signed [10:0] e;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        s      = a[31] ^ b[31];
        g      = 1'b0;
        st     = 1'b0;
        mant   = '0;
        prod   = '0;
        e      = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            fp_mul = {3'b100, QNAN};
        end else if (a_inf || b_inf) begin
            fp_mul = {3'b000, s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            fp_mul = {3'b000, s, 31'd0};
        end else begin
            prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
            e    = 11'(a[30:23]) + 11'(b[30:23]) - 11'd127;
            if (prod[47]) begin
                mant = {1'b0, prod[47:24]};
                g    = prod[23];
                st   = |prod[22:0];
                e    = e + 11'sd1;
            end else begin
                mant = {1'b0, prod[46:23]};
                g    = prod[22];
                st   = |prod[21:0];
            end
            if (g && (st || mant[0])) mant = mant + 25'd1;
            if (mant[24]) begin
                mant = mant >> 1;
                e    = e + 11'sd1;
            end
            if (e >= 11'sd255)     fp_mul = {3'b010, s, 8'hFF, 23'd0};
            else if (e <= 11'sd0)  fp_mul = {3'b001, s, 31'd0};
            else                   fp_mul = {3'b000, s, e[7:0], mant[22:0]};
        end
    endfunction

    function automatic logic [34:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic               g, st, sticky;
        logic [31:0]        x, y;
        logic [27:0]        mx, my, sum;
        logic [7:0]         d;
        logic [24:0]        mant;
        logic signed [10:0] e;
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        g = 1'b0; st = 1'b0; sticky = 1'b0;
        x = a; y = b; mx = '0; my = '0; sum = '0; d = '0; mant = '0; e = '0;
        if (a_nan || b_nan) begin
            fp_add = {3'b000, QNAN};
        end else if (a_inf && b_inf && (a[31] != b[31])) begin
            fp_add = {3'b100, QNAN};
        end else if (a_inf) begin
            fp_add = {3'b000, a};
        end else if (b_inf) begin
            fp_add = {3'b000, b};
        end else if (a_zero && b_zero) begin
            fp_add = {3'b000, a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            fp_add = {3'b000, b};
        end else if (b_zero) begin
            fp_add = {3'b000, a};
        end else begin
            if (a[30:0] < b[30:0]) begin
                x = b;
                y = a;
            end
            d  = x[30:23] - y[30:23];
            mx = {2'b01, x[22:0], 3'b000};
            my = {2'b01, y[22:0], 3'b000};
            if (d >= 8'd27) begin
                sticky = 1'b1;
                my     = '0;
            end else begin
                sticky = |(my & ((28'd1 << d) - 28'd1));
                my     = my >> d;
            end
            my[0] = my[0] | sticky;
            sum   = (x[31] == y[31]) ? mx + my : mx - my;
            e     = 11'(x[30:23]);
            if (sum == 28'd0) begin
                fp_add = 35'd0;
            end else begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 11'sd1;
                end else begin
                    for (int i = 0; i < 26; i++) begin
                        if (!sum[26]) begin
                            sum = sum << 1;
                            e   = e - 11'sd1;
                        end
                    end
                end
                mant = {1'b0, sum[26:3]};
                g    = sum[2];
                st   = |sum[1:0];
                if (g && (st || mant[0])) mant = mant + 25'd1;
                if (mant[24]) begin
                    mant = mant >> 1;
                    e    = e + 11'sd1;
                end
                if (e >= 11'sd255)     fp_add = {3'b010, x[31], 8'hFF, 23'd0};
                else if (e <= 11'sd0)  fp_add = {3'b001, x[31], 31'd0};
                else                   fp_add = {3'b000, x[31], e[7:0], mant[22:0]};
            end
        end
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [TAP_AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [DATA_WIDTH-1:0]   r_line [NUM_TAPS];
    logic [DATA_WIDTH-1:0]   r_coef [NUM_TAPS];
    logic [31:0]             r_op_a, r_op_b;
    logic                    r_op_vld, r_op_first;
    logic [34:0]             r_p_data [P_LEN];
    logic [P_LEN-1:0]        r_p_vld, r_p_first;
    logic [31:0]             r_acc, r_y;
    logic [34:0]             w_mul, w_add;
    logic                    w_accept, w_coef_wr, w_out_load, w_last_mac, w_last_drain;

    assign w_last_mac   = (r_cnt == CNT_W'(NUM_TAPS - 1));
    assign w_last_drain = (r_cnt == CNT_W'(MAC_LAT - 1));

    always_comb begin
        w_state_nxt = r_state;
        x_ready_o   = 1'b0;
        y_valid_o   = 1'b0;
        busy_o      = (r_state != S_IDLE);
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                x_ready_o = ce_i;
                w_accept  = ce_i && x_valid_i;
                if (w_accept) w_state_nxt = S_MAC;
            end
            S_MAC:   if (w_last_mac) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_drain) w_state_nxt = S_OUT;
            S_OUT: begin
                y_valid_o   = ce_i;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else if (ce_i) begin
            r_state <= w_state_nxt;
            if (r_state != w_state_nxt)                    r_cnt <= '0;
            else if (r_state == S_MAC || r_state == S_DRAIN) r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_coef_wr  = (r_state == S_IDLE) && coef_we_i &&
                        ({1'b0, coef_addr_i} < (TAP_AW + 1)'(NUM_TAPS));
    assign w_out_load = (r_state == S_DRAIN) && w_last_drain;
    assign w_mul      = fp_mul(r_op_a, r_op_b);
    // The first tap of a sample adds +0 instead of the previous accumulator value.
    assign w_add      = fp_add(r_p_data[P_LEN-1][31:0], r_p_first[P_LEN-1] ? 32'd0 : r_acc);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_line[i] <= '0;
                r_coef[i] <= '0;
            end
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_vld   <= 1'b0;
            r_op_first <= 1'b0;
            for (int i = 0; i < P_LEN; i++) r_p_data[i] <= '0;
            r_p_vld    <= '0;
            r_p_first  <= '0;
            r_acc      <= '0;
            r_y        <= '0;
        end else if (ce_i) begin
            if (w_coef_wr) r_coef[coef_addr_i] <= coef_data_i;
            if (w_accept) begin
                r_line[r_wr_ptr] <= x_i;
                r_wr_ptr <= (r_wr_ptr == TAP_AW'(NUM_TAPS - 1)) ? '0 : r_wr_ptr + TAP_AW'(1);
                r_rd_ptr <= r_wr_ptr;
            end else if (r_state == S_MAC) begin
                r_rd_ptr <= (r_rd_ptr == '0) ? TAP_AW'(NUM_TAPS - 1) : r_rd_ptr - TAP_AW'(1);
            end
            r_op_a      <= r_line[r_rd_ptr];
            r_op_b      <= r_coef[r_cnt[TAP_AW-1:0]];
            r_op_vld    <= (r_state == S_MAC);
            r_op_first  <= (r_state == S_MAC) && (r_cnt == '0);
            r_p_data[0] <= w_mul;
            r_p_vld[0]  <= r_op_vld;
            r_p_first[0] <= r_op_first;
            for (int i = 1; i < P_LEN; i++) begin
                r_p_data[i]  <= r_p_data[i-1];
                r_p_vld[i]   <= r_p_vld[i-1];
                r_p_first[i] <= r_p_first[i-1];
            end
            if (r_p_vld[P_LEN-1]) r_acc <= w_add[31:0];
            if (w_out_load)       r_y   <= r_acc;
        end
    end

    assign y_o = r_y;

`ifdef FIR_STATUS_EN
    logic [2:0] r_acc_flags, r_flags;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc_flags <= '0;
            r_flags     <= '0;
        end else if (ce_i) begin
            if (w_accept)
                r_acc_flags <= '0;
            else if (r_p_vld[P_LEN-1])
                r_acc_flags <= r_acc_flags | w_add[34:32] | r_p_data[P_LEN-1][34:32];
            if (w_out_load) r_flags <= r_acc_flags;
        end
    end

    assign {invalid_o, overflow_o, underflow_o} = r_flags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{w_add[34:32], r_p_data[P_LEN-1][34:32]};
    assign {invalid_o, overflow_o, underflow_o} = 3'b000;
`endif

endmodule
